mul_64_3_recon: RTL



---
 rtl/div3_pkg.sv | 24 ++
 rtl/mul3_chunk.sv | 24 ++
 rtl/mul_64_3_recon.sv | 96 +++++++++
 3 files changed

// File: rtl/div3_pkg.sv
// +--------------------------------------------------------------------+
// | div3_pkg : shared constants and state type for the divide-by-3     |
// |            family and its 3*Q+R reconstruction engine.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package div3_pkg;

    localparam int Q_W      = 63;
    localparam int X_W      = 64;
    localparam int CHUNK    = 6;
    localparam int N_CHUNKS = 11;
    localparam int REM_MAX  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mul3_chunk.sv
// +--------------------------------------------------------------------+
// | mul3_chunk : combinational 3*q + carry_in on one 6-bit chunk.      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mul3_chunk
    import div3_pkg::*;
(
    input  logic [CHUNK-1:0] q,
    input  logic [1:0]       carry_in,
    output logic [CHUNK-1:0] sum,
    output logic [1:0]       carry_out
);

    logic [CHUNK+1:0] w_s;

    // 3*q as q + 2q; the result never exceeds 3*63+3 = 192, so 8 bits suffice.
    assign w_s = {2'b00, q} + {1'b0, q, 1'b0} + {{CHUNK{1'b0}}, carry_in};
    assign {carry_out, sum} = w_s;

endmodule

`default_nettype wire

// File: rtl/mul_64_3_recon.sv
// +--------------------------------------------------------------------+
// | mul_64_3_recon : serial X = 3*Q + R reconstruction, one 6-bit Q     |
// |                  chunk per cycle, valid/ready on both sides.       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module mul_64_3_recon
    import div3_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [Q_W-1:0] Q,
    input  logic [1:0]     R,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [X_W-1:0] X,
    output logic           ovf,
    output logic           r_err
);

    localparam logic [3:0] LAST_K  = 4'(N_CHUNKS - 1);
    localparam logic [1:0] R_LIMIT = 2'(REM_MAX);

    state_t         r_state;
    logic [3:0]     r_k;
    logic [Q_W-1:0] r_q;
    logic [1:0]     r_carry;
    logic [CHUNK-1:0] w_sum;
    logic [1:0]     w_cout;

    // The shift register feeds zeros in from the top, so the final chunk
    // arrives as Q[62:60] already zero-extended.
    mul3_chunk u_chunk (
        .q         (r_q[CHUNK-1:0]),
        .carry_in  (r_carry),
        .sum       (w_sum),
        .carry_out (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            X         <= '0;
            ovf       <= 1'b0;
            r_err     <= 1'b0;
            r_k       <= '0;
            r_carry   <= '0;
            r_q       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_q      <= Q;
                        r_carry  <= R;
                        r_err    <= (R > R_LIMIT);
                        r_k      <= '0;
                        in_ready <= 1'b0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    r_q <= r_q >> CHUNK;
                    if (r_k == LAST_K) begin
                        // Only four result bits fit; anything above is overflow.
                        X[X_W-1 -: 4] <= w_sum[3:0];
                        ovf           <= |{w_cout, w_sum[CHUNK-1:4]};
                        out_valid     <= 1'b1;
                        r_state       <= DONE;
                    end else begin
                        X[CHUNK*r_k +: CHUNK] <= w_sum;
                        r_carry               <= w_cout;
                        r_k                   <= r_k + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
